// File: rtl/simmem_row_scheduler.sv
// Single-bank open-page row-buffer timing scheduler: arbitrates read/write address requests,
// tracks the open row and releases the request ID once its modelled service delay has elapsed.
module simmem_row_scheduler #(
    parameter int AddrWidth         = 16,
    parameter int RowBufferLenWidth = 8,
    parameter int IDWidth           = 4,
    parameter int RowHitCost        = 10,
    parameter int PrechargeCost     = 50,
    parameter int ActivationCost    = 45,
    parameter int CostWidth         = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 waddr_valid_i,
    output logic                                 waddr_ready_o,
    input  logic [AddrWidth-1:0]                 waddr_addr_i,
    input  logic [IDWidth-1:0]                   waddr_id_i,
    input  logic                                 raddr_valid_i,
    output logic                                 raddr_ready_o,
    input  logic [AddrWidth-1:0]                 raddr_addr_i,
    input  logic [IDWidth-1:0]                   raddr_id_i,
    output logic                                 done_valid_o,
    input  logic                                 done_ready_i,
    output logic                                 done_is_write_o,
    output logic [IDWidth-1:0]                   done_id_o,
    output logic                                 row_open_o,
    output logic [AddrWidth-RowBufferLenWidth-1:0] open_row_o
);

    localparam int RowWidth = AddrWidth - RowBufferLenWidth;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVICE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  row_open;
    logic [RowWidth-1:0]   open_row;
    logic                  rr_write;
    logic [CostWidth-1:0]  counter;
    logic [IDWidth-1:0]    held_id;
    logic                  held_write;

    logic [RowWidth-1:0]   read_row;
    logic [RowWidth-1:0]   write_row;
    logic                  read_hit;
    logic                  write_hit;
    logic                  grant_read;
    logic                  grant_write;
    logic                  accept;
    logic [RowWidth-1:0]   sel_row;
    logic                  sel_hit;
    logic [CostWidth-1:0]  sel_cost;
    logic                  unused_low_bits;

    // Service delay for an access given whether it hits the open row and whether any row is open.
    function automatic logic [CostWidth-1:0] access_cost(input logic hit, input logic any_open);
        logic [CostWidth-1:0] cost;
        if (hit)
            cost = CostWidth'(RowHitCost);
        else if (!any_open)
            cost = CostWidth'(ActivationCost + RowHitCost);
        else
            cost = CostWidth'(PrechargeCost + ActivationCost + RowHitCost);
        return cost;
    endfunction

    assign read_row        = raddr_addr_i[AddrWidth-1:RowBufferLenWidth];
    assign write_row       = waddr_addr_i[AddrWidth-1:RowBufferLenWidth];
    assign read_hit        = row_open && (read_row == open_row);
    assign write_hit       = row_open && (write_row == open_row);
    assign unused_low_bits = ^{raddr_addr_i[RowBufferLenWidth-1:0], waddr_addr_i[RowBufferLenWidth-1:0]};

    // Row-hit first when exactly one contender hits; otherwise the round-robin flag decides.
    always_comb begin
        grant_read  = 1'b0;
        grant_write = 1'b0;
        if (state == IDLE) begin
            if (raddr_valid_i && waddr_valid_i) begin
                if (read_hit != write_hit) begin
                    grant_read  = read_hit;
                    grant_write = write_hit;
                end else if (rr_write) begin
                    grant_write = 1'b1;
                end else begin
                    grant_read  = 1'b1;
                end
            end else begin
                grant_read  = raddr_valid_i;
                grant_write = waddr_valid_i;
            end
        end
    end

    assign accept   = grant_read || grant_write;
    assign sel_row  = grant_write ? write_row : read_row;
    assign sel_hit  = grant_write ? write_hit : read_hit;
    assign sel_cost = access_cost(sel_hit, row_open);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SERVICE;
            SERVICE: if (counter == CostWidth'(1)) state_next = DONE;
            DONE:    if (done_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            row_open   <= 1'b0;
            open_row   <= '0;
            rr_write   <= 1'b0;
            counter    <= '0;
            held_id    <= '0;
            held_write <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                held_id    <= grant_write ? waddr_id_i : raddr_id_i;
                held_write <= grant_write;
                open_row   <= sel_row;
                row_open   <= 1'b1;
                rr_write   <= grant_read;
                counter    <= sel_cost - CostWidth'(1);
            end else if (state == SERVICE) begin
                counter <= counter - CostWidth'(1);
            end
        end
    end

    assign raddr_ready_o   = grant_read;
    assign waddr_ready_o   = grant_write;
    assign done_valid_o    = (state == DONE);
    assign done_id_o       = (state == DONE) ? held_id : '0;
    assign done_is_write_o = (state == DONE) && held_write;
    assign row_open_o      = row_open;
    assign open_row_o      = open_row;

endmodule
